imem_port_arbiter: RTL and testbench
====================================

Name: imem_port_arbiter

Overview:
- Shares the single synchronous-read port of the instruction ROM between two requesters: the core fetch stage and a Wishbone B4 classic slave interface (debug/loader reads).
- Fetch has priority. Wishbone is guaranteed a slot after at most MAX_STARVE consecutive fetch grants while it is pending.
- Sits between the fetch stage, the Wishbone interconnect and the ROM port; the ROM returns data one cycle after the enable.

Parameters:
- SIZE_BYTE, 2048: ROM size in bytes.
- MAX_STARVE, 4: maximum consecutive fetch grants while a Wishbone read waits. Range 1..15.
- ADDRWIDTH, $clog2(SIZE_BYTE) (localparam): byte-address width.

Ports:
- i_clk  in  1  clock
- i_rst_n  in  1  asynchronous active-low reset
- i_fd_req  in  1  fetch wants an instruction this cycle
- i_fd_clr  in  1  fetch flush; inject a bubble instead of reading
- i_fd_addr  in  ADDRWIDTH  fetch byte address
- o_fd_stall  out  1  fetch request not accepted this cycle; core holds address
- o_fd_valid  out  1  o_fd_rd carries a fetch result this cycle
- o_fd_rd  out  32  fetched instruction (0 on bubble)
- i_wb_cyc  in  1  Wishbone cycle
- i_wb_stb  in  1  Wishbone strobe
- i_wb_we  in  1  Wishbone write enable (unsupported)
- i_wb_adr  in  ADDRWIDTH  Wishbone byte address
- o_wb_dat  out  32  Wishbone read data
- o_wb_ack  out  1  Wishbone acknowledge
- o_wb_err  out  1  Wishbone error
- o_mem_en  out  1  ROM read enable (combinational)
- o_mem_addr  out  ADDRWIDTH  ROM byte address (combinational)
- i_mem_rd  in  32  ROM read data, valid the cycle after o_mem_en

Behaviour:
- Reset (i_rst_n low, asynchronous):
  - o_fd_valid, o_wb_ack and o_wb_err are 0. o_fd_rd and o_wb_dat are 0.
  - o_mem_en is forced to 0. Starvation counter is 0. Owner register is OWN_NONE. Wishbone FSM is WB_IDLE.
  - A read in flight at reset is discarded.
- Wishbone FSM states: WB_IDLE, WB_WAIT, WB_RESP.
  - wb_pend = i_wb_cyc & i_wb_stb & state==WB_IDLE.
  - WB_RESP lasts exactly one cycle. Strobe is ignored in WB_RESP, so a held strobe is never re-issued that cycle.
- Grant decision, evaluated each cycle N:
  - fd_want = i_fd_req & !i_fd_clr.
  - wb_read = wb_pend & !i_wb_we & i_wb_adr[1:0]==0.
  - If wb_read and (!fd_want or starve_cnt==MAX_STARVE): grant Wishbone. Drive o_mem_en=1, o_mem_addr=i_wb_adr. Owner becomes OWN_WB, state goes to WB_WAIT, starve_cnt clears to 0.
  - Else if fd_want: grant fetch. Drive o_mem_en=1, o_mem_addr=i_fd_addr. Owner becomes OWN_FD. If wb_read, starve_cnt increments (saturating at MAX_STARVE); otherwise it clears.
  - Else: o_mem_en=0 and owner becomes OWN_NONE.
- o_fd_stall = fd_want & !fetch_granted, combinational in cycle N.
- Flush:
  - i_fd_clr=1 with i_fd_req=1 consumes no ROM slot.
  - In N+1: o_fd_valid=1, o_fd_rd=0.
  - A fetch issued in an earlier cycle still returns normally; flush applies only to the cycle it is asserted in.
- Fetch return: owner OWN_FD in N+1 gives o_fd_valid=1 and o_fd_rd=i_mem_rd. Otherwise o_fd_valid=0 and o_fd_rd=0.
- Wishbone return, in WB_WAIT at N+1:
  - If i_wb_cyc=1: o_wb_ack=1, o_wb_dat=i_mem_rd, state goes to WB_RESP, then WB_IDLE the following cycle.
  - If i_wb_cyc dropped: data discarded, no ack, state goes to WB_IDLE.
- Error path:
  - A pending request with i_wb_we=1 or a misaligned address uses no ROM slot.
  - State goes to WB_RESP. In the next cycle o_wb_err=1, o_wb_ack=0, o_wb_dat=0.
- ack and err are mutually exclusive and each lasts one cycle per request. At most one ROM read is issued per cycle.
- o_fd_rd, o_wb_dat, o_fd_valid, o_wb_ack and o_wb_err are registered or derived from registered owner/state. Only o_fd_stall, o_mem_en and o_mem_addr are combinational.

Decomposition:
- Package imem_arb_pkg:
  - enum owner_e {OWN_NONE, OWN_FD, OWN_WB}
  - enum wb_state_e {WB_IDLE, WB_WAIT, WB_RESP}
  - constant STARVE_W = 4
- One sub-module, imem_arb_starve_ctr: saturating counter with inc, clr and at_max outputs, parameterised by MAX_STARVE.

Test Plan:
- Reset mid-read: fetch addr 0x010 issued, i_rst_n low before N+1 -> o_fd_valid=0, o_mem_en=0, all outputs 0; first fetch after release returns correctly.
- Back-to-back fetch, ROM word4=0xDEADBEEF, word5=0x00000013, addr 0x010 then 0x014 -> o_fd_valid=1 on consecutive cycles with those values; o_fd_stall=0 throughout.
- Starvation, MAX_STARVE=4, fetch requesting every cycle, Wishbone read 0x020 pending:
  - Fetch granted 4 cycles, stall=1 on the 5th with o_mem_addr=0x020.
  - ack=1 the next cycle with ROM word8.
  - Fetch resumes and the held strobe is not re-issued.
- Flush: i_fd_req=1, i_fd_clr=1, addr 0x040 -> o_mem_en=0; N+1 o_fd_valid=1, o_fd_rd=0. An in-flight fetch from N-1 still returns its data.
- Wishbone write to 0x000, and read of 0x002 -> o_wb_err=1 for one cycle, o_wb_ack=0, o_wb_dat=0, no ROM access.
- Cycle abort: Wishbone read 0x030 granted, i_wb_cyc=0 at N+1 -> no ack; FSM back to WB_IDLE; next request accepted.

Source files
------------

// File: rtl/imem_arb_pkg.sv
// Shared types and constants for the instruction-ROM port arbiter.
package imem_arb_pkg;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_FD   = 2'd1,
    OWN_WB   = 2'd2
  } owner_e;

  typedef enum logic [1:0] {
    WB_IDLE = 2'd0,
    WB_WAIT = 2'd1,
    WB_RESP = 2'd2
  } wb_state_e;

  localparam int STARVE_W = 4;

endpackage

// File: rtl/imem_arb_starve_ctr.sv
// Saturating count of consecutive fetch grants made while a Wishbone read waits.
module imem_arb_starve_ctr
  import imem_arb_pkg::*;
#(
  parameter int MAX_STARVE = 4
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                inc,
  input  logic                clr,
  output logic [STARVE_W-1:0] cnt,
  output logic                at_max
);

  localparam logic [STARVE_W-1:0] MAX_C = STARVE_W'(MAX_STARVE);

  logic [STARVE_W-1:0] cnt_p1;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt_p1 <= '0;
    end else if (clr) begin
      cnt_p1 <= '0;
    end else if (inc && cnt_p1 != MAX_C) begin
      cnt_p1 <= cnt_p1 + 1'b1;
    end
  end

  assign cnt    = cnt_p1;
  assign at_max = (cnt_p1 == MAX_C);

endmodule

// File: rtl/imem_port_arbiter.sv
// Shares the synchronous-read instruction ROM port between core fetch (priority)
// and a Wishbone B4 classic read slave, with a bounded Wishbone wait.
module imem_port_arbiter
  import imem_arb_pkg::*;
#(
  parameter  int SIZE_BYTE  = 2048,
  parameter  int MAX_STARVE = 4,
  localparam int ADDRWIDTH  = $clog2(SIZE_BYTE)
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_fd_req,
  input  logic                 i_fd_clr,
  input  logic [ADDRWIDTH-1:0] i_fd_addr,
  output logic                 o_fd_stall,
  output logic                 o_fd_valid,
  output logic [31:0]          o_fd_rd,
  input  logic                 i_wb_cyc,
  input  logic                 i_wb_stb,
  input  logic                 i_wb_we,
  input  logic [ADDRWIDTH-1:0] i_wb_adr,
  output logic [31:0]          o_wb_dat,
  output logic                 o_wb_ack,
  output logic                 o_wb_err,
  output logic                 o_mem_en,
  output logic [ADDRWIDTH-1:0] o_mem_addr,
  input  logic [31:0]          i_mem_rd
);

  wb_state_e state_p1, state_nxt;
  owner_e    owner_p1, owner_nxt;
  logic      bubble_p1;
  logic      err_p1, err_nxt;

  logic fd_want, wb_pend, wb_read, wb_bad;
  logic grant_wb, grant_fd, at_max;
  logic [STARVE_W-1:0] starve_cnt;

  // Stage 0: grant decision and ROM request (combinational)
  assign fd_want  = i_fd_req & ~i_fd_clr;
  assign wb_pend  = i_wb_cyc & i_wb_stb & (state_p1 == WB_IDLE);
  assign wb_bad   = wb_pend & (i_wb_we | (i_wb_adr[1:0] != 2'b00));
  assign wb_read  = wb_pend & ~wb_bad;
  assign grant_wb = wb_read & (~fd_want | at_max);
  assign grant_fd = fd_want & ~grant_wb;

  assign o_mem_en   = (grant_wb | grant_fd) & i_rst_n;
  assign o_mem_addr = grant_wb ? i_wb_adr : i_fd_addr;
  assign o_fd_stall = fd_want & ~grant_fd;

  assign owner_nxt = grant_wb ? OWN_WB : (grant_fd ? OWN_FD : OWN_NONE);

  imem_arb_starve_ctr #(
    .MAX_STARVE (MAX_STARVE)
  ) u_starve_ctr (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .inc     (grant_fd & wb_read),
    .clr     (grant_wb | ~wb_read),
    .cnt     (starve_cnt),
    .at_max  (at_max)
  );

  // Stage 1: ownership of the read in flight and Wishbone FSM state
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      owner_p1  <= OWN_NONE;
      bubble_p1 <= 1'b0;
      state_p1  <= WB_IDLE;
      err_p1    <= 1'b0;
    end else begin
      owner_p1  <= owner_nxt;
      bubble_p1 <= i_fd_req & i_fd_clr;
      state_p1  <= state_nxt;
      err_p1    <= err_nxt;
    end
  end

  always_comb begin
    state_nxt = state_p1;
    err_nxt   = 1'b0;
    case (state_p1)
      WB_IDLE: begin
        if (grant_wb) begin
          state_nxt = WB_WAIT;
        end else if (wb_bad) begin
          state_nxt = WB_RESP;
          err_nxt   = 1'b1;
        end
      end
      // A dropped cycle abandons the returning data without an ack.
      WB_WAIT: state_nxt = i_wb_cyc ? WB_RESP : WB_IDLE;
      WB_RESP: state_nxt = WB_IDLE;
      default: state_nxt = WB_IDLE;
    endcase
  end

  always_comb begin
    o_wb_ack = (state_p1 == WB_WAIT) & i_wb_cyc;
    o_wb_err = (state_p1 == WB_RESP) & err_p1;
    o_wb_dat = o_wb_ack ? i_mem_rd : 32'd0;
  end

  assign o_fd_valid = (owner_p1 == OWN_FD) | bubble_p1;
  assign o_fd_rd    = (owner_p1 == OWN_FD) ? i_mem_rd : 32'd0;

endmodule

// File: tb/tb_imem_port_arbiter.sv
// Directed bench for imem_port_arbiter with a behavioural synchronous ROM.
module tb_imem_port_arbiter;

  localparam int AW = 11;

  logic          i_clk = 1'b0;
  logic          i_rst_n;
  logic          i_fd_req, i_fd_clr;
  logic [AW-1:0] i_fd_addr;
  logic          o_fd_stall, o_fd_valid;
  logic [31:0]   o_fd_rd;
  logic          i_wb_cyc, i_wb_stb, i_wb_we;
  logic [AW-1:0] i_wb_adr;
  logic [31:0]   o_wb_dat;
  logic          o_wb_ack, o_wb_err;
  logic          o_mem_en;
  logic [AW-1:0] o_mem_addr;
  logic [31:0]   i_mem_rd;

  logic [31:0] rom [512];
  int n_tests = 0;
  int n_fail  = 0;

  always #5 i_clk = ~i_clk;

  imem_port_arbiter #(.SIZE_BYTE(2048), .MAX_STARVE(4)) dut (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_fd_req   (i_fd_req),
    .i_fd_clr   (i_fd_clr),
    .i_fd_addr  (i_fd_addr),
    .o_fd_stall (o_fd_stall),
    .o_fd_valid (o_fd_valid),
    .o_fd_rd    (o_fd_rd),
    .i_wb_cyc   (i_wb_cyc),
    .i_wb_stb   (i_wb_stb),
    .i_wb_we    (i_wb_we),
    .i_wb_adr   (i_wb_adr),
    .o_wb_dat   (o_wb_dat),
    .o_wb_ack   (o_wb_ack),
    .o_wb_err   (o_wb_err),
    .o_mem_en   (o_mem_en),
    .o_mem_addr (o_mem_addr),
    .i_mem_rd   (i_mem_rd)
  );

  always_ff @(posedge i_clk) begin
    if (o_mem_en) i_mem_rd <= rom[o_mem_addr[AW-1:2]];
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 512; i++) rom[i] = 32'hA000_0000 | i;
    rom[4] = 32'hDEAD_BEEF;
    rom[5] = 32'h0000_0013;
    i_mem_rd = '0;
    i_rst_n = 1'b0;
    i_fd_req = 0; i_fd_clr = 0; i_fd_addr = '0;
    i_wb_cyc = 0; i_wb_stb = 0; i_wb_we = 0; i_wb_adr = '0;
    step(); step();
    chk("rst_fd_valid", 32'(o_fd_valid), 32'd0);
    chk("rst_fd_rd", o_fd_rd, 32'd0);
    chk("rst_wb_ack", 32'(o_wb_ack), 32'd0);
    chk("rst_wb_err", 32'(o_wb_err), 32'd0);
    chk("rst_wb_dat", o_wb_dat, 32'd0);
    chk("rst_mem_en", 32'(o_mem_en), 32'd0);
    i_rst_n = 1'b1;
    step();

    // Reset while a fetch is in flight
    i_fd_req = 1; i_fd_addr = 11'h010;
    #1;
    chk("midrst_issue_en", 32'(o_mem_en), 32'd1);
    chk("midrst_issue_addr", 32'(o_mem_addr), 32'h010);
    step();
    i_rst_n = 0; i_fd_req = 0;
    #1;
    chk("midrst_fd_valid", 32'(o_fd_valid), 32'd0);
    chk("midrst_fd_rd", o_fd_rd, 32'd0);
    chk("midrst_mem_en", 32'(o_mem_en), 32'd0);
    step();
    i_rst_n = 1;
    step();
    i_fd_req = 1; i_fd_addr = 11'h010;
    step();
    i_fd_req = 0;
    #1;
    chk("postrst_fd_valid", 32'(o_fd_valid), 32'd1);
    chk("postrst_fd_rd", o_fd_rd, 32'hDEAD_BEEF);
    step();

    // Back-to-back fetch
    i_fd_req = 1; i_fd_addr = 11'h010;
    #1;
    chk("b2b_stall0", 32'(o_fd_stall), 32'd0);
    step();
    i_fd_addr = 11'h014;
    #1;
    chk("b2b_valid0", 32'(o_fd_valid), 32'd1);
    chk("b2b_rd0", o_fd_rd, 32'hDEAD_BEEF);
    chk("b2b_stall1", 32'(o_fd_stall), 32'd0);
    step();
    i_fd_req = 0;
    #1;
    chk("b2b_valid1", 32'(o_fd_valid), 32'd1);
    chk("b2b_rd1", o_fd_rd, 32'h0000_0013);
    step();

    // Starvation bound with fetch requesting every cycle
    i_fd_req = 1; i_fd_addr = 11'h000;
    i_wb_cyc = 1; i_wb_stb = 1; i_wb_we = 0; i_wb_adr = 11'h020;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk($sformatf("starve_fd_stall%0d", i), 32'(o_fd_stall), 32'd0);
      chk($sformatf("starve_fd_addr%0d", i), 32'(o_mem_addr), 32'h000);
      step();
    end
    #1;
    chk("starve_wb_stall", 32'(o_fd_stall), 32'd1);
    chk("starve_wb_en", 32'(o_mem_en), 32'd1);
    chk("starve_wb_addr", 32'(o_mem_addr), 32'h020);
    step();
    #1;
    chk("starve_ack", 32'(o_wb_ack), 32'd1);
    chk("starve_dat", o_wb_dat, 32'hA000_0008);
    chk("starve_fd_resume", 32'(o_fd_stall), 32'd0);
    chk("starve_fd_novalid", 32'(o_fd_valid), 32'd0);
    step();
    #1;
    chk("resp_ack0", 32'(o_wb_ack), 32'd0);
    chk("resp_no_reissue", 32'(o_mem_addr), 32'h000);
    chk("resp_fd_stall", 32'(o_fd_stall), 32'd0);
    chk("resp_fd_rd", o_fd_rd, 32'hA000_0000);
    i_wb_cyc = 0; i_wb_stb = 0;
    step();
    i_fd_req = 0;
    #1;
    chk("after_resp_ack", 32'(o_wb_ack), 32'd0);
    step();

    // Flush with an older fetch still returning
    i_fd_req = 1; i_fd_addr = 11'h014;
    step();
    i_fd_clr = 1; i_fd_addr = 11'h040;
    #1;
    chk("flush_mem_en", 32'(o_mem_en), 32'd0);
    chk("flush_stall", 32'(o_fd_stall), 32'd0);
    chk("flush_prev_valid", 32'(o_fd_valid), 32'd1);
    chk("flush_prev_rd", o_fd_rd, 32'h0000_0013);
    step();
    i_fd_req = 0; i_fd_clr = 0;
    #1;
    chk("flush_bubble_valid", 32'(o_fd_valid), 32'd1);
    chk("flush_bubble_rd", o_fd_rd, 32'd0);
    step();
    #1;
    chk("flush_idle_valid", 32'(o_fd_valid), 32'd0);

    // Write and misaligned read both end in a one-cycle error
    for (int k = 0; k < 2; k++) begin
      i_wb_cyc = 1; i_wb_stb = 1;
      i_wb_we  = (k == 0);
      i_wb_adr = (k == 0) ? 11'h000 : 11'h002;
      #1;
      chk($sformatf("err%0d_no_rom", k), 32'(o_mem_en), 32'd0);
      step();
      #1;
      chk($sformatf("err%0d_err", k), 32'(o_wb_err), 32'd1);
      chk($sformatf("err%0d_ack", k), 32'(o_wb_ack), 32'd0);
      chk($sformatf("err%0d_dat", k), o_wb_dat, 32'd0);
      chk($sformatf("err%0d_resp_no_rom", k), 32'(o_mem_en), 32'd0);
      i_wb_cyc = 0; i_wb_stb = 0; i_wb_we = 0;
      step();
      #1;
      chk($sformatf("err%0d_clear", k), 32'(o_wb_err), 32'd0);
    end

    // Cycle abort after grant
    i_wb_cyc = 1; i_wb_stb = 1; i_wb_adr = 11'h030;
    #1;
    chk("abort_en", 32'(o_mem_en), 32'd1);
    chk("abort_addr", 32'(o_mem_addr), 32'h030);
    step();
    i_wb_cyc = 0; i_wb_stb = 0;
    #1;
    chk("abort_no_ack", 32'(o_wb_ack), 32'd0);
    step();
    #1;
    chk("abort_no_ack2", 32'(o_wb_ack), 32'd0);
    i_wb_cyc = 1; i_wb_stb = 1; i_wb_adr = 11'h000;
    #1;
    chk("abort_next_en", 32'(o_mem_en), 32'd1);
    chk("abort_next_addr", 32'(o_mem_addr), 32'h000);
    step();
    #1;
    chk("abort_next_ack", 32'(o_wb_ack), 32'd1);
    chk("abort_next_dat", o_wb_dat, 32'hA000_0000);
    i_wb_cyc = 0; i_wb_stb = 0;
    step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
